// File: rtl/trivium_prng_fifo.sv
// Trivium keystream generator feeding a show-ahead word buffer.
// The core is bit-sliced OUTPUT_BITS steps per enabled cycle; the top sequences reseed, warm-up and prefetch.
module trivium_core #(
  parameter int OUTPUT_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [79:0]            iv_i,
  input  logic [79:0]            key_i,
  output logic [OUTPUT_BITS-1:0] stream_o
);
  logic [287:0] state_q;
  logic [287:0] state_cur;
  logic [287:0] state_step;
  logic         armed_q;
  logic         t1, t2, t3;

  // rst only arms a load: key/IV are folded in on the first enabled cycle,
  // so the owner may update them on the same edge that leaves rst.
  always_comb begin
    t1         = 1'b0;
    t2         = 1'b0;
    t3         = 1'b0;
    stream_o   = '0;
    state_cur  = state_q;
    if (armed_q) begin
      state_cur          = '0;
      state_cur[79:0]    = key_i;
      state_cur[172:93]  = iv_i;
      state_cur[287:285] = 3'b111;
    end
    state_step = state_cur;
    for (int i = 0; i < OUTPUT_BITS; i++) begin
      t1 = state_step[65] ^ state_step[92];
      t2 = state_step[161] ^ state_step[176];
      t3 = state_step[242] ^ state_step[287];
      stream_o[OUTPUT_BITS-1-i] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (state_step[90] & state_step[91]) ^ state_step[170];
      t2 = t2 ^ (state_step[174] & state_step[175]) ^ state_step[263];
      t3 = t3 ^ (state_step[285] & state_step[286]) ^ state_step[68];
      state_step = {state_step[286:177], t2, state_step[175:93], t1, state_step[91:0], t3};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b1;
    end else if (en) begin
      state_q <= state_step;
      armed_q <= 1'b0;
    end
  end
endmodule

module trivium_prng_fifo #(
  parameter int WORDSIZE     = 32,
  parameter int OUTPUT_BITS  = 8,
  parameter int DEPTH        = 4,
  parameter int RESEED_WORDS = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [79:0]            key_i,
  input  logic [79:0]            iv_i,
  input  logic                   refr_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [WORDSIZE-1:0]    prng_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int INIT_CYCLES    = 1152 / OUTPUT_BITS;
  localparam int FETCH_INTERVAL = WORDSIZE / OUTPUT_BITS;
  localparam int PTR_W          = $clog2(DEPTH);
  localparam int LVL_W          = $clog2(DEPTH) + 1;
  localparam int INIT_W         = $clog2(INIT_CYCLES + 1);
  localparam int FETCH_W        = $clog2(FETCH_INTERVAL + 1);
  localparam int RCNT_W         = (RESEED_WORDS > 0) ? $clog2(RESEED_WORDS + 1) : 1;

  generate
    if ((WORDSIZE % OUTPUT_BITS) != 0 || (1152 % OUTPUT_BITS) != 0 || DEPTH < 2) begin : g_bad_params
      $error("trivium_prng_fifo: illegal WORDSIZE/OUTPUT_BITS/DEPTH combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_RST, S_INIT, S_FILL, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic [79:0]           key_q, iv_q;
  logic                  load_pend_q;
  logic [INIT_W-1:0]     init_cnt_q;
  logic [FETCH_W-1:0]    fetch_cnt_q;
  logic [WORDSIZE-1:0]   word_q, word_d;
  logic [WORDSIZE-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q;
  logic [RCNT_W-1:0]     rcnt_q;
  logic [OUTPUT_BITS-1:0] stream;
  logic                  refr_take, pop, push, fill_en, core_en, core_rst, last_chunk, reseed_hit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign refr_take  = refr_i && (state_q != S_RST);
  assign pop        = valid_o && ready_i;
  // A word may only start with room in the buffer, so a push never overflows.
  assign fill_en    = (state_q == S_FILL) && ((fetch_cnt_q != '0) || (level_q < LVL_W'(DEPTH)));
  assign core_en    = (state_q == S_INIT) || fill_en;
  assign last_chunk = (FETCH_INTERVAL == 1) || (fetch_cnt_q == FETCH_W'(1));
  assign push       = fill_en && last_chunk && !refr_take;
  assign word_d     = (word_q << OUTPUT_BITS) | WORDSIZE'(stream);
  assign reseed_hit = (RESEED_WORDS > 0) && push && (rcnt_q == RCNT_W'(RESEED_WORDS - 1));

  trivium_core #(.OUTPUT_BITS(OUTPUT_BITS)) u_core (
    .clk      (clk_i),
    .rst      (core_rst),
    .en       (core_en),
    .iv_i     (iv_q),
    .key_i    (key_q),
    .stream_o (stream)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_RST;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy_o   = 1'b0;
    core_rst = 1'b0;
    case (state_q)
      S_RST: begin
        busy_o   = 1'b1;
        core_rst = 1'b1;
        state_d  = S_INIT;
      end
      S_INIT: begin
        busy_o = 1'b1;
        if (init_cnt_q == '0) state_d = S_FILL;
      end
      S_FILL: begin
        if (reseed_hit) state_d = S_RST;
        else if (fetch_cnt_q == '0 && level_q == LVL_W'(DEPTH)) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (level_q < LVL_W'(DEPTH)) state_d = S_FILL;
      end
      default: state_d = S_RST;
    endcase
    if (refr_take) state_d = S_RST;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q       <= '0;
      iv_q        <= '0;
      load_pend_q <= 1'b1;
      init_cnt_q  <= '0;
      fetch_cnt_q <= '0;
      word_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rcnt_q      <= '0;
    end else if (refr_take) begin
      key_q       <= key_i;
      iv_q        <= iv_i;
      load_pend_q <= 1'b0;
      fetch_cnt_q <= '0;
      word_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rcnt_q      <= '0;
    end else begin
      if (state_q == S_RST) begin
        init_cnt_q <= INIT_W'(INIT_CYCLES - 1);
        if (load_pend_q) begin
          key_q       <= key_i;
          iv_q        <= iv_i;
          load_pend_q <= 1'b0;
        end
      end else if (state_q == S_INIT && init_cnt_q != '0) begin
        init_cnt_q <= init_cnt_q - INIT_W'(1);
      end

      if (fill_en) begin
        word_q <= word_d;
        if (fetch_cnt_q == '0) fetch_cnt_q <= FETCH_W'(FETCH_INTERVAL - 1);
        else                   fetch_cnt_q <= fetch_cnt_q - FETCH_W'(1);
      end

      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      level_q <= level_q + LVL_W'(1);
      else if (pop && !push) level_q <= level_q - LVL_W'(1);

      // Automatic reseed keeps the key and buffered words, stepping only the IV.
      if (reseed_hit) begin
        iv_q   <= iv_q + 80'd1;
        rcnt_q <= '0;
      end else if (push && RESEED_WORDS > 0) begin
        rcnt_q <= rcnt_q + RCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= word_d;
  end

  assign valid_o = (level_q != '0);
  assign level_o = level_q;
  assign prng_o  = valid_o ? mem[rd_ptr_q] : '0;
endmodule

// File: tb/tb_trivium_prng_fifo.sv
// Bench for trivium_prng_fifo: words are scoreboarded against a bit-serial textbook
// Trivium model; sequencing latencies and buffer levels are checked at fixed edges.
`timescale 1ns/1ps
module tb_trivium_prng_fifo;
  localparam int WS = 32;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [79:0]   key = '0;
  logic [79:0]   iv = '0;
  logic          refr = 1'b0;
  logic          ready = 1'b0;
  logic          valid, busy;
  logic [WS-1:0] prng;
  logic [LW-1:0] level;
  logic          refr_r = 1'b0;
  logic          ready_r = 1'b0;
  logic          valid_r, busy_r;
  logic [WS-1:0] prng_r;
  logic [LW-1:0] level_r;

  int            n_checks = 0;
  int            n_pass = 0;
  int            pops = 0;
  int            pops_r = 0;
  logic [WS-1:0] exp_q[$];
  logic [WS-1:0] exp_r[$];

  always #5 clk = ~clk;

  trivium_prng_fifo dut (
    .clk_i(clk), .rst_ni(rst_n), .key_i(key), .iv_i(iv), .refr_i(refr), .ready_i(ready),
    .valid_o(valid), .prng_o(prng), .busy_o(busy), .level_o(level)
  );

  trivium_prng_fifo #(.RESEED_WORDS(2)) dut_r (
    .clk_i(clk), .rst_ni(rst_n), .key_i(key), .iv_i(iv), .refr_i(refr_r), .ready_i(ready_r),
    .valid_o(valid_r), .prng_o(prng_r), .busy_o(busy_r), .level_o(level_r)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Textbook Trivium with 1-based state bits s1..s288; first keystream bit lands in the word MSB.
  task automatic model_push(input bit to_r, input logic [79:0] k, input logic [79:0] v, input int nwords);
    logic [1:288]  s;
    logic          t1, t2, t3, z;
    logic [WS-1:0] w;
    int            nbits;
    s = '0;
    for (int i = 1; i <= 80; i++) begin
      s[i]    = k[i-1];
      s[93+i] = v[i-1];
    end
    s[286] = 1'b1;
    s[287] = 1'b1;
    s[288] = 1'b1;
    w = '0;
    nbits = 0;
    for (int n = 0; n < 1152 + nwords * WS; n++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      s  = {t3, s[1:92], t1, s[94:176], t2, s[178:287]};
      if (n >= 1152) begin
        w = {w[WS-2:0], z};
        nbits++;
        if (nbits == WS) begin
          if (to_r) exp_r.push_back(w);
          else      exp_q.push_back(w);
          nbits = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1 && ready === 1'b1) begin
      pops++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL main_word: got 0x%0h, expected nothing (model queue empty) at %0t", prng, $time);
      end else begin
        check("main_word", prng, exp_q.pop_front());
      end
    end
    if (valid_r === 1'b1 && ready_r === 1'b1) begin
      pops_r++;
      if (exp_r.size() == 0) begin
        n_checks++;
        $display("FAIL reseed_word: got 0x%0h, expected nothing (model queue empty) at %0t", prng_r, $time);
      end else begin
        check("reseed_word", prng_r, exp_r.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Auto-reseed instance: second push at edge 153 reseeds while two words stay buffered.
  initial begin
    wait (rst_n == 1'b0);
    @(posedge rst_n);
    repeat (153) @(posedge clk);
    #1;
    check("auto_reseed_busy", busy_r, 1);
    check("auto_reseed_level", level_r, 2);
    check("auto_reseed_valid", valid_r, 1);
    ready_r = 1'b1;
    tick(2);
    check("auto_reseed_drained", level_r, 0);
    check("auto_reseed_still_busy", busy_r, 1);
  end

  initial begin
    int first_valid, first_idle, first_full, pop0, last_refr;
    bit do_refr;
    model_push(0, '0, '0, 400);
    for (int i = 0; i < 64; i++) model_push(1, '0, 80'(i), 2);

    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", valid, 0);
    check("rst_level", level, 0);
    check("rst_prng", prng, 0);
    check("rst_busy", busy, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    first_valid = 0;
    first_idle  = 0;
    first_full  = 0;
    for (int e = 1; e <= 400 && first_full == 0; e++) begin
      tick(1);
      if (first_valid == 0 && valid) first_valid = e;
      if (first_idle == 0 && !busy)  first_idle = e;
      if (first_full == 0 && level == 3'd4) first_full = e;
    end
    check("first_valid_edge", first_valid, 149);
    check("busy_fall_edge", first_idle, 145);
    check("full_edge", first_full, 161);
    tick(10);
    check("hold_level", level, 4);
    check("hold_busy", busy, 0);

    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("pulse_level_after_pop", level, 3);
    tick(4);
    check("pulse_level_refilling", level, 3);
    tick(1);
    check("pulse_refilled", level, 4);

    ready = 1'b1;
    tick(1);
    check("pre_refr_level", level, 3);
    key  = {16'($urandom), $urandom, $urandom};
    iv   = {16'($urandom), $urandom, $urandom};
    refr = 1'b1;
    tick(1);
    refr = 1'b0;
    exp_q.delete();
    model_push(0, key, iv, 400);
    check("refr_level", level, 0);
    check("refr_valid", valid, 0);
    check("refr_busy", busy, 1);
    first_valid = 0;
    first_idle  = 0;
    for (int e = 1; e <= 300 && first_valid == 0; e++) begin
      tick(1);
      if (first_valid == 0 && valid) first_valid = e;
      if (first_idle == 0 && !busy)  first_idle = e;
    end
    check("refr_busy_len", first_idle, 145);
    check("refr_valid_edge", first_valid, 149);
    pop0 = pops;
    tick(400);
    check("stream_rate", pops - pop0, 100);

    last_refr = 0;
    for (int c = 0; c < 1500; c++) begin
      ready   = ($urandom_range(0, 3) != 0);
      do_refr = (c - last_refr > 4) && ($urandom_range(0, 299) == 0 || c - last_refr > 600);
      if (do_refr) begin
        key       = {16'($urandom), $urandom, $urandom};
        iv        = {16'($urandom), $urandom, $urandom};
        last_refr = c;
      end
      refr = do_refr;
      tick(1);
      refr = 1'b0;
      if (do_refr) begin
        exp_q.delete();
        model_push(0, key, iv, 400);
      end
    end

    ready = 1'b0;
    tick(3);
    refr = 1'b1;
    tick(1);
    refr = 1'b0;
    exp_q.delete();
    model_push(0, key, iv, 8);
    tick(153);
    check("pre_reset_level", level, 2);
    check("pre_reset_busy", busy, 0);
    check("auto_reseed_pops", pops_r >= 6, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", valid, 0);
    check("async_rst_level", level, 0);
    check("async_rst_prng", prng, 0);
    check("async_rst_busy", busy, 1);
    check("async_rst_level_r", level_r, 0);
    check("async_rst_busy_r", busy_r, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
